// File: rtl/shared_logic_arbiter_pkg.sv
// Shared definitions for the shared_logic_arbiter block.
//   - Opcode constants for the shared AND/XOR unit.
//   - FSM state encoding. The unused encoding 2'd3 is illegal and recovers to StIdle.
package shared_logic_arbiter_pkg;

   localparam logic OP_AND = 1'b0;
   localparam logic OP_XOR = 1'b1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/shared_logic_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner selection, reusable by other arbiters.
// Ports:
//   req_i      N_REQ-bit request vector
//   ptr_i      index of the highest-priority requester this round
//   onehot_o   one-hot winner (all zero when req_i is zero)
//   idx_o      winner index (0 when req_i is zero)
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned IdxW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IdxW-1:0]  ptr_i,
   output logic [N_REQ-1:0] onehot_o,
   output logic [IdxW-1:0]  idx_o
);

   logic [IdxW-1:0] cand;
   logic            found;

   // Scan ptr_i, ptr_i+1, ... modulo N_REQ; the first asserted request wins.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      cand     = '0;
      found    = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = IdxW'((32'(ptr_i) + k) % N_REQ);
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            onehot_o[cand] = 1'b1;
            idx_o          = cand;
         end
      end
   end

endmodule

// File: rtl/shared_logic_arbiter.sv
// shared_logic_arbiter: round-robin scheduler sharing one registered AND/XOR unit
// between N_REQ requesters, one operation in flight at a time.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   req_i, op_i        per-requester request level and opcode (0 = AND, 1 = XOR)
//   a_in_i, b_in_i     packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt_o              one-cycle registered one-hot grant (high in EXEC)
//   busy_o             high while in EXEC or DONE
//   res_valid_o/res_ready_i  result handshake
//   res_id_o, res_data_o     owner index and value of the held result
module shared_logic_arbiter
   import shared_logic_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IdxW = $clog2(N_REQ)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ-1:0]       op_i,
   input  logic [N_REQ*WIDTH-1:0] a_in_i,
   input  logic [N_REQ*WIDTH-1:0] b_in_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic                   busy_o,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [IdxW-1:0]        res_id_o,
   output logic [WIDTH-1:0]       res_data_o
);

   state_e           state_q, state_d;
   logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             op_q, op_d;
   logic [IdxW-1:0]  cap_id_q, cap_id_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             res_valid_q, res_valid_d;
   logic [IdxW-1:0]  res_id_q, res_id_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] win_onehot;
   logic [IdxW-1:0]  win_idx;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             sel_op;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req_i    (req_i),
      .ptr_i    (rr_ptr_q),
      .onehot_o (win_onehot),
      .idx_o    (win_idx)
   );

   // Operand mux for the current winner.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_idx == IdxW'(i)) begin
            sel_a  = a_in_i[i*WIDTH +: WIDTH];
            sel_b  = b_in_i[i*WIDTH +: WIDTH];
            sel_op = op_i[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      cap_id_d    = cap_id_q;
      gnt_d       = '0;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      case (state_q)
         StIdle: begin
            if (|req_i) begin
               a_d      = sel_a;
               b_d      = sel_b;
               op_d     = sel_op;
               cap_id_d = win_idx;
               gnt_d    = win_onehot;
               // Explicit wrap keeps non-power-of-two N_REQ correct.
               rr_ptr_d = (win_idx == IdxW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
               state_d  = StExec;
            end
         end
         StExec: begin
            res_data_d  = (op_q == OP_XOR) ? (a_q ^ b_q) : (a_q & b_q);
            res_id_d    = cap_id_q;
            res_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (res_valid_q && res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= 1'b0;
         cap_id_q    <= '0;
         gnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         cap_id_q    <= cap_id_d;
         gnt_q       <= gnt_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign busy_o      = busy_q;
   assign res_valid_o = res_valid_q;
   assign res_id_o    = res_id_q;
   assign res_data_o  = res_data_q;

endmodule
